// File: rtl/divider_pkg.sv
// Shared constants for the sequential signed divider: default width,
// one-hot state encoding and counter sizing helpers.
`default_nettype none

package divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_LOAD    = 6'b000010;
  localparam logic [5:0] S_ITER    = 6'b000100;
  localparam logic [5:0] S_CORRECT = 6'b001000;
  localparam logic [5:0] S_FIXSIGN = 6'b010000;
  localparam logic [5:0] S_DONE    = 6'b100000;

  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int div_iter_last(input int w);
    return w - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_addsub.sv
// Combinational W-bit adder/subtractor: operand B is inverted by sub_i,
// which also serves as the carry-in.
`default_nettype none

module div_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {W{sub_i}}) + {{(W-1){1'b0}}, sub_i};

endmodule

`default_nettype wire

// File: rtl/divider.sv
// Sequential signed divider: radix-2 non-restoring division on operand
// magnitudes, followed by truncating sign correction.
`default_nettype none

module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz,
  output logic             ovf
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(div_iter_last(WIDTH));

  logic [5:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH:0]   a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;

  logic             sx, sy;
  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH:0]   add_a, add_s;
  logic             add_sub;

  assign sx    = x_q[WIDTH-1];
  assign sy    = y_q[WIDTH-1];
  // Negating the most negative value yields 2^(WIDTH-1) read as unsigned.
  assign x_abs = sx ? -x_q : x_q;
  assign y_abs = sy ? -y_q : y_q;

  div_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i   (add_a),
    .b_i   (m_q),
    .sub_i (add_sub),
    .sum_o (add_s)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    add_a   = a_q;
    add_sub = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = X;
          y_d     = Y;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d   = '0;
        q_d   = x_abs;
        m_d   = {1'b0, y_abs};
        cnt_d = '0;
        dz_d  = 1'b0;
        ovf_d = 1'b0;
        if (y_q == '0) begin
          quot_d  = '1;
          rem_d   = x_q;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        add_a   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        add_sub = ~a_q[WIDTH];
        a_d     = add_s;
        q_d     = {q_q[WIDTH-2:0], ~add_s[WIDTH]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == ITER_LAST) begin
          state_d = S_CORRECT;
        end
      end
      S_CORRECT: begin
        if (a_q[WIDTH]) begin
          a_d = add_s;
        end
        state_d = S_FIXSIGN;
      end
      S_FIXSIGN: begin
        quot_d  = (sx ^ sy) ? -q_q : q_q;
        rem_d   = sx ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        ovf_d   = (x_q == {1'b1, {(WIDTH-1){1'b0}}}) && (y_q == '1);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// Self-checking bench for divider: cycle-level reference model plus
// directed literal checks and randomized operands.
`default_nettype none

module tb_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [31:0] X, Y;
  logic        busy, done, dz, ovf;
  logic [31:0] quotient, remainder;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_cmp = 1'b0;

  divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: truncating signed division with special cases.
  function automatic res_t ref_div(input logic [31:0] x, input logic [31:0] y);
    res_t   r;
    longint xs, ys;
    r = '0;
    if (y == 32'd0) begin
      r.q  = 32'hFFFF_FFFF;
      r.r  = x;
      r.dz = 1'b1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r.q   = 32'h8000_0000;
      r.r   = 32'd0;
      r.ovf = 1'b1;
    end else begin
      xs  = longint'($signed(x));
      ys  = longint'($signed(y));
      r.q = 32'(xs / ys);
      r.r = 32'(xs % ys);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Latency model: busy for m_len cycles after the accepting edge, done in the last.
  int   m_left, m_len;
  res_t m_res, exp_out;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_left  <= 0;
      m_len   <= 0;
      m_res   <= '0;
      exp_out <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= (Y == 32'd0) ? 2 : 36;
        m_len  <= (Y == 32'd0) ? 2 : 36;
        m_res  <= ref_div(X, Y);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left - 1 == 1) exp_out <= m_res;
      else if (m_left == m_len) begin
        exp_out.dz  <= 1'b0;
        exp_out.ovf <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_busy", 32'(busy), 32'(m_left > 0));
      chk("cmp_done", 32'(done), 32'(m_left == 1));
      chk("cmp_quotient", quotient, exp_out.q);
      chk("cmp_remainder", remainder, exp_out.r);
      chk("cmp_dz", 32'(dz), 32'(exp_out.dz));
      chk("cmp_ovf", 32'(ovf), 32'(exp_out.ovf));
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output res_t r, output int lat, output int bcnt);
    @(posedge clk); #1;
    wait_idle();
    X = x; Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X = $urandom; Y = $urandom;
    lat = -1; bcnt = 0; r = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = n - 1;
        r = '{q: quotient, r: remainder, dz: dz, ovf: ovf};
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_lit(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input logic eovf, input int elat);
    res_t r;
    int   lat, bcnt;
    run_op(x, y, r, lat, bcnt);
    chk({name, "_q"}, r.q, eq);
    chk({name, "_r"}, r.r, er);
    chk({name, "_dz"}, 32'(r.dz), 32'(edz));
    chk({name, "_ovf"}, 32'(r.ovf), 32'(eovf));
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_busy"}, 32'(bcnt), 32'(elat + 1));
  endtask

  initial begin
    res_t r;
    int   lat, bcnt, ndone, sel;
    logic [31:0] rx, ry;

    rst_b = 1'b0; start = 1'b0; X = '0; Y = '0;
    repeat (2) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    rst_b = 1'b1;

    run_lit("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 35);
    run_lit("m100_7", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 35);
    run_lit("p100_m7", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 35);
    run_lit("dz5", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1);
    run_lit("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 35);
    run_lit("min_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 35);

    // Starts and operand changes while busy must not disturb the running op.
    @(posedge clk); #1;
    wait_idle();
    X = 32'd100; Y = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; r = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = (c == 5 || c == 20);
      X = $urandom; Y = $urandom;
      @(negedge clk);
      if (done) begin
        ndone++;
        r.q = quotient; r.r = remainder;
      end
    end
    start = 1'b0;
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_q", r.q, 32'd14);
    chk("ign_r", r.r, 32'd2);

    // Reset mid-run aborts at once.
    @(posedge clk); #1;
    wait_idle();
    X = 32'd100; Y = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst_b = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_ndone", 32'(ndone), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    run_lit("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 35);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rx  = $urandom;
      ry  = $urandom;
      case (sel)
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'h8000_0000;
        3, 4: begin
          ry = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) ry = -ry;
        end
        5: rx = 32'($urandom_range(0, 50)) - 32'd25;
        default: ;
      endcase
      run_op(rx, ry, r, lat, bcnt);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/divider.md
# divider

Sequential signed integer divider: the inverse of the radix-8 Booth multiplier unit, sharing its operand conventions (32-bit two's-complement X/Y, single-clock FSM + datapath). It implements radix-2 non-restoring division on operand magnitudes using a 33-bit add/subtract path, then applies truncating sign correction. It sits beside the multiplier in the arithmetic block, started by the top-level controller with a one-cycle `start` and reporting completion with `done`.

## Interface
- `WIDTH`, 32, operand/result width; internal partial remainder is WIDTH+1 bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `X`  in  WIDTH  dividend, two's complement; captured on accepting edge.
- `Y`  in  WIDTH  divisor, two's complement; captured on accepting edge.
- `busy`  out  1  high from accepting edge until `done` cycle ends.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  WIDTH  signed quotient, held until next accepted start.
- `remainder`  out  WIDTH  signed remainder, held until next accepted start.
- `dz`  out  1  divide-by-zero flag, valid with/after `done`.
- `ovf`  out  1  overflow flag (X = -2^(WIDTH-1), Y = -1).

## Operation
- States: IDLE, LOAD, ITER, CORRECT, FIXSIGN, DONE (one-hot).
- IDLE: `start`=1 at an edge -> latch X, Y, sign bits sx, sy; go LOAD. `start` in any other state is ignored.
- LOAD: A (WIDTH+1) <= 0; Q <= |X|; M <= {0, |Y|}; counter <= 0; clear `dz`, `ovf`. If Y == 0 -> DONE directly with quotient = all ones, remainder = X, `dz`=1. Else -> ITER.
- ITER (WIDTH cycles, counter 0..WIDTH-1): shift {A,Q} left 1; if A was non-negative A <= A - M else A <= A + M; Q[0] <= ~A_new[WIDTH]. counter == WIDTH-1 -> CORRECT.
- CORRECT: if A negative, A <= A + M (restore remainder).
- FIXSIGN: quotient <= (sx ^ sy) ? -Q : Q; remainder <= sx ? -A[WIDTH-1:0] : A[WIDTH-1:0]; `ovf` <= (X == -2^(WIDTH-1)) & (Y == -1).
- DONE: `done`=1 for exactly one cycle -> IDLE.
- Arithmetic: truncation toward zero; remainder takes dividend's sign; |remainder| < |Y|. |X| of -2^(WIDTH-1) is 2^(WIDTH-1) as unsigned (no loss). Overflow quotient wraps to 0x8000_0000, remainder 0.
- Outputs change only in FIXSIGN (or LOAD for dz path); otherwise held.

## Timing
- Accepting edge = edge 0. Normal path: LOAD at edge 1, ITER edges 2..WIDTH+1, CORRECT edge WIDTH+2, FIXSIGN edge WIDTH+3, DONE entered edge WIDTH+3 -> `done` high in the cycle after edge 35 (WIDTH=32), IDLE after edge 36.
- Divide-by-zero: `done` high in the cycle after edge 1; IDLE after edge 2.
- `busy` high in the cycle after edge 0 through the `done` cycle; low in IDLE. Back-to-back start accepted at first IDLE edge.
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `dz`=0, `ovf`=0, state IDLE, counter 0.
- Reset asserted mid-operation: immediate abort, all of the above; no `done` emitted.
- X/Y changes after edge 0 have no effect on the running operation.

## Structure
- Shared package: state encoding constants, `WIDTH` default 32, `CNT_W` = clog2(WIDTH), ITER terminal count.
- Sub-module `div_addsub`: (WIDTH+1)-bit adder/subtractor, operand-B XOR with `sub` as carry-in (same scheme as the existing carry-skip adder's 33-bit path); combinational, instantiated once. FSM, registers, counter and sign fix stay in `divider`.

## Test plan
- X=100, Y=7, start pulse -> `done` 35 cycles after accepting edge, quotient=14, remainder=2, dz=0, ovf=0, busy high 36 cycles.
- X=-100, Y=7 -> quotient=0xFFFF_FFF2 (-14), remainder=0xFFFF_FFFE (-2); X=100, Y=-7 -> quotient=-14, remainder=2.
- X=5, Y=0 -> `done` after edge 1, dz=1, quotient=0xFFFF_FFFF, remainder=5.
- X=0x8000_0000, Y=0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0, ovf=1; X=0x8000_0000, Y=1 -> quotient=0x8000_0000, ovf=0.
- Start pulses and X/Y changes at edges 5 and 20 of a 100/7 run -> ignored, result unchanged (14, 2), single `done`.
- rst_b low at edge 10 of a run -> all outputs 0 at once, no `done`; new start after release -> correct result with normal latency.
